// File: rtl/string_reader_pkg.sv
// string_reader_pkg: FSM states, blank character code and default widths for the string reader
package string_reader_pkg;
    localparam int DEF_CHAR_W = 4;
    localparam int DEF_IDX_W  = 4;
    localparam int BLANK_CODE = 0;
    typedef enum logic [2:0] {IDLE, FETCH, PRESENT, WAIT, FINISH} state_t;
endpackage

// File: rtl/string_reader_tick_divider.sv
// tick_divider: pacing counter; tick is high on the TICK_DIV-th enabled cycle after clear
module tick_divider #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && cnt == CW'(TICK_DIV - 1);
    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/string_reader.sv
// string_reader: walks a combinational string ROM and presents each character over valid/ready, paced by tick_divider.
// Defining STRING_READER_BLANK_EN appends one BLANK_CODE character after the last index of every pass.
module string_reader
    import string_reader_pkg::*;
#(
    parameter int CHAR_W   = DEF_CHAR_W,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int TICK_DIV = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              loop,
    output logic [IDX_W-1:0]  counter_caracter,
    input  logic [CHAR_W-1:0] caracter,
    input  logic [IDX_W-1:0]  len_string,
    output logic [CHAR_W-1:0] char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              done
);
    state_t state, next;
    logic [IDX_W-1:0] last_idx;
    logic [CHAR_W-1:0] fetch_code;
    logic loop_r, tick, last, pass_end;
    assign last = counter_caracter == last_idx;
    assign char_valid = state == PRESENT;
    assign busy = state != IDLE;
    assign done = state == FINISH;
`ifdef STRING_READER_BLANK_EN
    logic blank_r;
    assign pass_end = blank_r;
    assign fetch_code = blank_r ? CHAR_W'(BLANK_CODE) : caracter;
    always_ff @(posedge clk) begin
        if (reset || next == IDLE) blank_r <= 1'b0;
        else if (state == WAIT && tick) blank_r <= last && !blank_r;
    end
`else
    assign pass_end = last;
    assign fetch_code = caracter;
`endif
    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(clk),
        .reset(reset),
        .clear(state != WAIT),
        .en(state == WAIT),
        .tick(tick)
    );
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? FETCH : IDLE;
            FETCH:   next = PRESENT;
            PRESENT: next = char_ready ? WAIT : PRESENT;
            WAIT:    next = !tick ? WAIT : (pass_end && !loop_r) ? FINISH : FETCH;
            default: next = IDLE;
        endcase
        if (abort) next = IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            counter_caracter <= '0;
            last_idx <= '0;
            loop_r <= 1'b0;
            char_out <= '0;
        end else begin
            state <= next;
            // the index holds on the last entry while the blank character is pending
            if (next == IDLE) counter_caracter <= '0;
            else if (state == WAIT && tick && (pass_end || !last))
                counter_caracter <= last ? '0 : counter_caracter + IDX_W'(1);
            if (state == IDLE && start) begin
                last_idx <= len_string;
                loop_r <= loop;
            end
            if (state == FETCH) char_out <= fetch_code;
        end
    end
endmodule

// File: tb/tb_string_reader.sv
// tb_string_reader: scoreboard bench for string_reader with TICK_DIV=1 and TICK_DIV=4 instances
module tb_string_reader;
`ifdef STRING_READER_BLANK_EN
    localparam int BL = 1;
`else
    localparam int BL = 0;
`endif
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, abort_a, loop_a, ready_a, valid_a, busy_a, done_a;
    logic [3:0] len_a, idx_a, car_a, char_a;
    logic rst_b, start_b, abort_b, loop_b, ready_b, valid_b, busy_b, done_b;
    logic [3:0] len_b, idx_b, car_b, char_b;
    logic [3:0] rom [16];
    logic [7:0] qa[$], qb[$];
    int hc_a[$], hc_b[$];
    int n_cmp = 0, n_err = 0, cyc = 0, hs_a = 0, hs_b = 0, dn_a = 0, dcyc_a = 0;

    initial rom = '{4'd1, 4'd7, 4'd6, 4'd8, 4'd9, 4'd7, 4'd6, 4'd3, 4'd10, 4'd4, 4'd2, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    assign car_a = rom[idx_a];
    assign car_b = rom[idx_b];

    string_reader #(.CHAR_W(4), .IDX_W(4), .TICK_DIV(1)) dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .abort(abort_a), .loop(loop_a),
        .counter_caracter(idx_a), .caracter(car_a), .len_string(len_a),
        .char_out(char_a), .char_valid(valid_a), .char_ready(ready_a), .busy(busy_a), .done(done_a));

    string_reader #(.CHAR_W(4), .IDX_W(4), .TICK_DIV(4)) dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .abort(abort_b), .loop(loop_b),
        .counter_caracter(idx_b), .caracter(car_b), .len_string(len_b),
        .char_out(char_b), .char_valid(valid_b), .char_ready(ready_b), .busy(busy_b), .done(done_b));

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [7:0] e;
        if (valid_a && ready_a) begin
            hs_a++;
            hc_a.push_back(cyc);
            if (qa.size() == 0) check("a_unexpected_char", 1, 0);
            else begin
                e = qa.pop_front();
                check("a_char", char_a, e[3:0]);
                check("a_index", idx_a, e[7:4]);
            end
        end
        if (done_a) begin
            dn_a++;
            dcyc_a = cyc;
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (valid_b && ready_b) begin
            hs_b++;
            hc_b.push_back(cyc);
            if (qb.size() == 0) check("b_unexpected_char", 1, 0);
            else begin
                e = qb.pop_front();
                check("b_char", char_b, e[3:0]);
                check("b_index", idx_b, e[7:4]);
            end
        end
    end

    task automatic nclk(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass_a(input int len);
        for (int i = 0; i <= len; i++) qa.push_back({4'(i), rom[i]});
        if (BL == 1) qa.push_back({4'(len), 4'd0});
    endtask

    task automatic wait_hs_a(input int n, input int budget);
        int t = 0;
        while (hs_a < n && t < budget) begin
            nclk(1);
            t++;
        end
        if (hs_a < n) check("a_handshake_timeout", hs_a, n);
    endtask

    task automatic wait_hs_b(input int n, input int budget);
        int t = 0;
        while (hs_b < n && t < budget) begin
            nclk(1);
            t++;
        end
        if (hs_b < n) check("b_handshake_timeout", hs_b, n);
    endtask

    task automatic wait_done_a(input int n, input int budget);
        int t = 0;
        while (dn_a < n && t < budget) begin
            nclk(1);
            t++;
        end
        if (dn_a < n) check("a_done_timeout", dn_a, n);
    endtask

    task automatic wait_valid_a(input int budget);
        int t = 0;
        while (!valid_a && t < budget) begin
            nclk(1);
            t++;
        end
        if (!valid_a) check("a_valid_timeout", 0, 1);
    endtask

    task automatic pulse_start_a;
        drive_edge();
        start_a = 1'b1;
        drive_edge();
        start_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base, d0, t0;
        rst_a = 1; start_a = 0; abort_a = 0; loop_a = 0; ready_a = 1; len_a = 4'd11;
        rst_b = 1; start_b = 0; abort_b = 0; loop_b = 0; ready_b = 1; len_b = 4'd11;
        nclk(3);
        check("reset_index", idx_a, 0);
        check("reset_char_out", char_a, 0);
        check("reset_valid", valid_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        drive_edge();
        rst_a = 0; rst_b = 0;

        // single pass, ready held high
        push_pass_a(11);
        hc_a.delete();
        base = hs_a; d0 = dn_a;
        drive_edge();
        start_a = 1; t0 = cyc;
        drive_edge();
        start_a = 0;
        wait_done_a(d0 + 1, 200);
        check("pass_handshakes", hs_a - base, 12 + BL);
        check("start_latency", hc_a[0] - t0, 2);
        for (int i = 1; i < hc_a.size(); i++) check("char_period", hc_a[i] - hc_a[i-1], 3);
        check("done_after_last_wait", dcyc_a - hc_a[hc_a.size()-1], 2);
        nclk(1);
        check("busy_after_done", busy_a, 0);
        check("done_single_cycle", done_a, 0);
        check("done_count_pass", dn_a - d0, 1);

        // backpressure on char index 2
        push_pass_a(11);
        base = hs_a; d0 = dn_a;
        pulse_start_a();
        wait_hs_a(base + 2, 50);
        drive_edge();
        ready_a = 0;
        wait_valid_a(10);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", valid_a, 1);
            check("stall_char", char_a, 6);
            check("stall_index", idx_a, 2);
            if (i < 4) nclk(1);
        end
        drive_edge();
        ready_a = 1;
        wait_done_a(d0 + 1, 200);
        check("stall_pass_handshakes", hs_a - base, 12 + BL);

        // loop mode, mid-pass start/len/loop changes ignored, abort while presenting
        push_pass_a(11);
        for (int i = 0; i < 4; i++) qa.push_back({4'(i), rom[i]});
        base = hs_a; d0 = dn_a;
        drive_edge();
        loop_a = 1; len_a = 4'd11; start_a = 1;
        drive_edge();
        start_a = 0;
        wait_hs_a(base + 3, 50);
        drive_edge();
        start_a = 1; len_a = 4'd2; loop_a = 0;
        drive_edge();
        start_a = 0;
        wait_hs_a(base + 16 + BL, 300);
        drive_edge();
        ready_a = 0;
        wait_valid_a(20);
        check("loop_present_index", idx_a, 4);
        drive_edge();
        abort_a = 1;
        drive_edge();
        abort_a = 0;
        check("abort_valid", valid_a, 0);
        check("abort_index", idx_a, 0);
        check("abort_busy", busy_a, 0);
        ready_a = 1;
        nclk(10);
        check("loop_no_done", dn_a - d0, 0);
        check("abort_no_more_chars", hs_a - base, 16 + BL);

        // single-character string
        qa.push_back({4'd0, rom[0]});
        if (BL == 1) qa.push_back({4'd0, 4'd0});
        len_a = 4'd0; loop_a = 0;
        base = hs_a; d0 = dn_a;
        pulse_start_a();
        wait_done_a(d0 + 1, 50);
        check("len0_handshakes", hs_a - base, 1 + BL);

        // start and abort together in IDLE
        base = hs_a;
        drive_edge();
        start_a = 1; abort_a = 1;
        drive_edge();
        start_a = 0; abort_a = 0;
        for (int i = 0; i < 3; i++) begin
            nclk(1);
            check("start_abort_busy", busy_a, 0);
        end
        check("start_abort_no_chars", hs_a - base, 0);

        // TICK_DIV=4 pacing, then reset during WAIT
        for (int i = 0; i < 3; i++) qb.push_back({4'(i), rom[i]});
        hc_b.delete();
        drive_edge();
        loop_b = 1; start_b = 1;
        drive_edge();
        start_b = 0;
        wait_hs_b(3, 100);
        check("div4_period_1", hc_b[1] - hc_b[0], 6);
        check("div4_period_2", hc_b[2] - hc_b[1], 6);
        drive_edge();
        check("div4_busy_in_wait", busy_b, 1);
        rst_b = 1;
        @(posedge clk);
        nclk(1);
        check("midwait_reset_index", idx_b, 0);
        check("midwait_reset_char_out", char_b, 0);
        check("midwait_reset_valid", valid_b, 0);
        check("midwait_reset_busy", busy_b, 0);
        check("midwait_reset_done", done_b, 0);
        drive_edge();
        rst_b = 0;
        nclk(12);
        check("b_no_chars_after_reset", hs_b, 3);

        check("a_scoreboard_drained", qa.size(), 0);
        check("b_scoreboard_drained", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
